prog_ctr: RTL and testbench
===========================

# prog_ctr

Program counter and fetch sequencer feeding the instruction memory and the branch-target LUT. Each cycle it supplies the current PC. On a taken branch it drives the LUT index from the instruction immediate and loads the LUT's combinational 16-bit output as the next PC. It owns the start/run/done lifecycle of a program and optionally counts retired instructions and taken branches.

## Interface
Parameters:
- PC_W, 16, PC width; equals LUT output width
- LUT_ADDR_W, 8, LUT index width
- ICNT_W, 32, retired-instruction counter width
- BCNT_W, 16, taken-branch counter width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  level-sampled start request
- halt  in  1  current instruction is a halt
- branch_en  in  1  current instruction is a LUT branch
- branch_cond  in  1  branch condition flag from ALU
- lut_idx  in  LUT_ADDR_W  branch immediate from current instruction
- lut_addr  out  LUT_ADDR_W  index to LUT
- lut_out  in  PC_W  target read from LUT, combinational
- pc  out  PC_W  current instruction address
- running  out  1  high in RUN
- done  out  1  high in DONE
- instr_cnt  out  ICNT_W  retired instructions
- branch_cnt  out  BCNT_W  taken branches

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset (rst_n=0 at edge) gives:
  - state=IDLE, pc=0, running=0, done=0, instr_cnt=0, branch_cnt=0.
  - Reset asserted mid-RUN or in DONE takes effect at that edge, with the same values.
- IDLE:
  - start=1 → RUN; pc stays 0.
  - All other inputs are ignored.
- RUN, evaluated each cycle in priority order:
  1. halt=1 → DONE; pc holds. The halt instruction counts as retired.
  2. branch_en=1 && branch_cond=1 → pc <= lut_out (taken branch).
  3. Otherwise → pc <= pc+1, modulo 2^PC_W. 0xFFFF wraps to 0x0000.
  - branch_en=1 with branch_cond=0 is not taken; pc increments.
  - halt and a taken branch in the same cycle: halt wins; the branch is not counted.
  - start is ignored in RUN.
- DONE:
  - pc holds; done=1.
  - start=1 → pc <= 0, instr_cnt and branch_cnt clear, state → RUN.
- lut_addr = lut_idx at all times, combinational passthrough. This lets the LUT resolve within the same cycle.
- lut_out is used only on a taken branch and is loaded verbatim, with no offset arithmetic.
- running and done are decoded directly from the state register.

## Timing
- pc is registered. A taken branch in cycle N yields pc=lut_out(lut_idx at N) in cycle N+1. There are no branch bubbles.
- Combinational path each cycle: lut_idx → lut_addr → LUT → lut_out → pc D-input.
- Start latency: start sampled at edge E puts the FSM in RUN after E; the first instruction at pc=0 executes in the cycle after E.
- Halt latency: halt sampled at edge E gives done=1 after E.
- Counters (when compiled in) update on the same edge as pc:
  - instr_cnt +1 per RUN cycle.
  - branch_cnt +1 per taken branch.
  - Both saturate at all-ones; they do not wrap.

## Configuration
- PROG_CTR_PERF_EN defined: instr_cnt and branch_cnt are live as specified.
- PROG_CTR_PERF_EN undefined: no counter flops are instantiated; instr_cnt and branch_cnt are tied to 0. Ports remain present in both builds.

## Structure
- Package prog_ctr_pkg holds:
  - typedef enum logic [1:0] pc_state_t {IDLE, RUN, DONE}
  - localparams for default PC_W, LUT_ADDR_W, ICNT_W, BCNT_W
- One sub-module, perf_sat_cnt: parameterised width; inputs clear and inc; saturating output.
  - Instantiated twice, only under PROG_CTR_PERF_EN.
- The FSM and the pc register live in prog_ctr itself.

## Test plan
- Reset/start: hold rst_n=0 for 2 cycles, then pulse start. Require:
  - pc=0, running=0, done=0 during reset.
  - running=1 after the start edge.
  - pc goes 0,1,2,3 over the next cycles.
- Taken branch: at pc=5, drive branch_en=1, branch_cond=1, lut_idx=0x2A, with the LUT model returning 0x0100. Require:
  - lut_addr=0x2A in the same cycle.
  - pc=0x0100 next cycle.
  - branch_cnt=1 (perf build).
- Not-taken branch: branch_en=1, branch_cond=0 at pc=7 → pc=8; branch_cnt unchanged.
- Wrap and saturation:
  - pc=0xFFFF with no branch → pc=0x0000.
  - Perf build with BCNT_W=2: five taken branches → branch_cnt=3.
- Halt priority and restart:
  - At pc=9, drive halt=1 together with a taken branch. Require done=1, pc=9 held, branch_cnt unchanged.
  - Then pulse start. Require pc=0, counters cleared, running=1.
- Reset mid-RUN and build variants:
  - Assert rst_n=0 at pc=0x40 → next cycle pc=0, IDLE.
  - Build without PROG_CTR_PERF_EN → instr_cnt=0 and branch_cnt=0 throughout the full program.

Source files
------------

// File: rtl/prog_ctr_pkg.sv
// prog_ctr_pkg: shared FSM state type and default widths for the program counter.
package prog_ctr_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} pc_state_t;
    localparam int PC_W_DEF       = 16;
    localparam int LUT_ADDR_W_DEF = 8;
    localparam int ICNT_W_DEF     = 32;
    localparam int BCNT_W_DEF     = 16;
endpackage

// File: rtl/perf_sat_cnt.sv
// perf_sat_cnt: saturating event counter with synchronous clear.
module perf_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            r_cnt <= '0;
        else if (inc && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end

    assign cnt = r_cnt;
endmodule

// File: rtl/prog_ctr.sv
// prog_ctr: program counter and IDLE/RUN/DONE fetch sequencer driving the branch-target LUT.
// Define PROG_CTR_PERF_EN to build the retired-instruction and taken-branch counters.
module prog_ctr
    import prog_ctr_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
    parameter int ICNT_W     = ICNT_W_DEF,
    parameter int BCNT_W     = BCNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  branch_en,
    input  logic                  branch_cond,
    input  logic [LUT_ADDR_W-1:0] lut_idx,
    output logic [LUT_ADDR_W-1:0] lut_addr,
    input  logic [PC_W-1:0]       lut_out,
    output logic [PC_W-1:0]       pc,
    output logic                  running,
    output logic                  done,
    output logic [ICNT_W-1:0]     instr_cnt,
    output logic [BCNT_W-1:0]     branch_cnt
);
    pc_state_t       r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic            w_run, w_taken, w_restart;

    assign lut_addr  = lut_idx;
    assign w_run     = r_state == RUN;
    assign w_restart = r_state == DONE && start;
    // halt outranks a simultaneous taken branch
    assign w_taken   = w_run && branch_en && branch_cond && !halt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_run ? (halt ? DONE : RUN) : (start ? RUN : r_state);
    end

    always_comb begin
        running = w_run;
        done    = r_state == DONE;
    end

    always_comb begin
        w_pc_nxt = w_restart ? '0
                 : (!w_run || halt) ? r_pc
                 : w_taken ? lut_out
                 : r_pc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_pc <= '0;
        else
            r_pc <= w_pc_nxt;
    end

    assign pc = r_pc;

`ifdef PROG_CTR_PERF_EN
    perf_sat_cnt #(.W(ICNT_W)) u_icnt (
        .clk(clk), .rst_n(rst_n), .clear(w_restart), .inc(w_run), .cnt(instr_cnt)
    );
    perf_sat_cnt #(.W(BCNT_W)) u_bcnt (
        .clk(clk), .rst_n(rst_n), .clear(w_restart), .inc(w_taken), .cnt(branch_cnt)
    );
`else
    assign instr_cnt  = '0;
    assign branch_cnt = '0;
`endif
endmodule

// File: tb/tb_prog_ctr.sv
// tb_prog_ctr: directed vector table plus randomized run against a behavioural model.
// A second instance with BCNT_W=2 shares the stimulus to exercise counter saturation.
module tb_prog_ctr;
`ifdef PROG_CTR_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, halt = 1'b0;
    logic        branch_en = 1'b0, branch_cond = 1'b0;
    logic [7:0]  lut_idx = '0, lut_addr, lut_addr2;
    logic [15:0] lut_out, lut_out2, pc, pc2;
    logic        running, done, running2, done2;
    logic [31:0] instr_cnt, instr_cnt2;
    logic [15:0] branch_cnt;
    logic [1:0]  branch_cnt2;
    logic [15:0] lut_mem [256];

    int checks = 0, failures = 0;
    int m_mode = 0, m_pc = 0;
    longint m_ic = 0, m_bc = 0;

    assign lut_out  = lut_mem[lut_addr];
    assign lut_out2 = lut_mem[lut_addr2];

    always #5 clk = ~clk;

    prog_ctr dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .branch_en(branch_en),
        .branch_cond(branch_cond), .lut_idx(lut_idx), .lut_addr(lut_addr), .lut_out(lut_out),
        .pc(pc), .running(running), .done(done), .instr_cnt(instr_cnt), .branch_cnt(branch_cnt)
    );

    prog_ctr #(.BCNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .branch_en(branch_en),
        .branch_cond(branch_cond), .lut_idx(lut_idx), .lut_addr(lut_addr2), .lut_out(lut_out2),
        .pc(pc2), .running(running2), .done(done2), .instr_cnt(instr_cnt2), .branch_cnt(branch_cnt2)
    );

    typedef struct {
        bit rn, st, hl, be, bc;
        logic [7:0] idx;
        logic [15:0] pc;
        bit run, dn;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program semantics stated directly: mode 0 idle, 1 run, 2 done.
    task automatic model_step();
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_ic = 0; m_bc = 0;
        end else if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            m_ic++;
            if (halt) m_mode = 2;
            else if (branch_en && branch_cond) begin
                m_pc = int'(lut_mem[lut_idx]);
                m_bc++;
            end else m_pc = (m_pc + 1) % 65536;
        end else if (start) begin
            m_mode = 1; m_pc = 0; m_ic = 0; m_bc = 0;
        end
    endtask

    task automatic check_model();
        chk("pc", 64'(pc), 64'(m_pc));
        chk("running", 64'(running), 64'(m_mode == 1));
        chk("done", 64'(done), 64'(m_mode == 2));
        chk("instr_cnt", 64'(instr_cnt), PERF ? 64'(m_ic) : 64'd0);
        chk("branch_cnt", 64'(branch_cnt), PERF ? 64'(m_bc > 65535 ? 65535 : m_bc) : 64'd0);
        chk("branch_cnt_sat2", 64'(branch_cnt2), PERF ? 64'(m_bc > 3 ? 3 : m_bc) : 64'd0);
        chk("pc2", 64'(pc2), 64'(m_pc));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        vec_t v[$];
        for (int i = 0; i < 256; i++) lut_mem[i] = 16'($urandom);
        lut_mem[8'h2A] = 16'h0100;
        lut_mem[8'h10] = 16'h0007;
        lut_mem[8'h20] = 16'hFFFF;
        lut_mem[8'h30] = 16'h0040;
        //            rn st hl be bc idx     pc        run dn
        v.push_back('{0, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 0});
        v.push_back('{0, 1, 0, 0, 0, 8'h00, 16'h0000, 0, 0});
        v.push_back('{1, 1, 0, 0, 0, 8'h00, 16'h0000, 1, 0});
        v.push_back('{1, 0, 0, 0, 0, 8'h00, 16'h0001, 1, 0});
        v.push_back('{1, 1, 0, 0, 0, 8'h00, 16'h0002, 1, 0});
        v.push_back('{1, 0, 0, 0, 0, 8'h00, 16'h0003, 1, 0});
        v.push_back('{1, 0, 0, 0, 0, 8'h00, 16'h0004, 1, 0});
        v.push_back('{1, 0, 0, 0, 0, 8'h00, 16'h0005, 1, 0});
        v.push_back('{1, 0, 0, 1, 1, 8'h2A, 16'h0100, 1, 0});
        v.push_back('{1, 0, 0, 1, 1, 8'h10, 16'h0007, 1, 0});
        v.push_back('{1, 0, 0, 1, 0, 8'h2A, 16'h0008, 1, 0});
        v.push_back('{1, 0, 0, 0, 0, 8'h00, 16'h0009, 1, 0});
        v.push_back('{1, 0, 1, 1, 1, 8'h2A, 16'h0009, 0, 1});
        v.push_back('{1, 0, 0, 1, 1, 8'h2A, 16'h0009, 0, 1});
        v.push_back('{1, 1, 0, 0, 0, 8'h00, 16'h0000, 1, 0});
        v.push_back('{1, 0, 0, 0, 0, 8'h00, 16'h0001, 1, 0});
        v.push_back('{1, 0, 0, 1, 1, 8'h20, 16'hFFFF, 1, 0});
        v.push_back('{1, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 0});
        v.push_back('{1, 0, 0, 1, 1, 8'h30, 16'h0040, 1, 0});
        v.push_back('{0, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 0});
        v.push_back('{1, 0, 0, 1, 1, 8'h2A, 16'h0000, 0, 0});
        v.push_back('{1, 0, 1, 0, 0, 8'h00, 16'h0000, 0, 0});
        foreach (v[k]) begin
            rst_n = v[k].rn; start = v[k].st; halt = v[k].hl;
            branch_en = v[k].be; branch_cond = v[k].bc; lut_idx = v[k].idx;
            #1 chk("lut_addr", 64'(lut_addr), 64'(v[k].idx));
            cycle();
            chk("vec_pc", 64'(pc), 64'(v[k].pc));
            chk("vec_running", 64'(running), 64'(v[k].run));
            chk("vec_done", 64'(done), 64'(v[k].dn));
        end
        // Five taken branches in a fresh run: narrow counter must pin at 3.
        start = 1'b1; halt = 1'b0; branch_en = 1'b0;
        cycle();
        start = 1'b0; branch_en = 1'b1; branch_cond = 1'b1; lut_idx = 8'h10;
        for (int i = 0; i < 5; i++) cycle();
        chk("sat_five", 64'(branch_cnt2), PERF ? 64'd3 : 64'd0);
        chk("bcnt_five", 64'(branch_cnt), PERF ? 64'd5 : 64'd0);
        for (int i = 0; i < 1500; i++) begin
            rst_n       = $urandom_range(0, 99) >= 2;
            start       = $urandom_range(0, 99) < 10;
            halt        = $urandom_range(0, 99) < 3;
            branch_en   = $urandom_range(0, 99) < 30;
            branch_cond = 1'($urandom);
            lut_idx     = 8'($urandom);
            #1 chk("lut_addr_rnd", 64'(lut_addr), 64'(lut_idx));
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
